// File: rtl/pacote_ritmo.sv
// Shared types for the rhythm game: FSM states, command encoding and the judgement rule.
package pacote_ritmo;

  localparam int LARG_CMD = 4;
  localparam logic [LARG_CMD-1:0] CMD_PAUSA = 4'hF;

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    PEDE    = 3'd1,
    CARREGA = 3'd2,
    ESPERA  = 3'd3,
    AVALIA  = 3'd4,
    FIM     = 3'd5
  } estado_t;

  // Returns {acerto, erro}; commands above 3 (CMD_PAUSA included) expect no press.
  function automatic logic [1:0] julgar(input logic [LARG_CMD-1:0] cmd,
                                        input logic [LARG_CMD-1:0] press);
    if (cmd < 4'd4) begin
      if (press == (4'b0001 << cmd[1:0])) return 2'b10;
      else return 2'b01;
    end
    return (press != 4'b0000) ? 2'b01 : 2'b00;
  endfunction

endpackage

// File: rtl/detector_de_borda.sv
// Rising-edge detector: one register per bit, combinational output, 1-cycle history.
// No flow control; out = in & ~prev every cycle.
module detector_de_borda #(
  parameter int LARGURA = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [LARGURA-1:0] entrada,
  output logic [LARGURA-1:0] borda
);

  logic [LARGURA-1:0] anterior;

  always_ff @(posedge clk) begin
    if (reset) anterior <= '0;
    else       anterior <= entrada;
  end

  assign borda = entrada & ~anterior;

endmodule

// File: rtl/avaliador_de_comandos.sv
// Paces commands, opens a fixed JANELA_CICLOS window, judges the first press; period JANELA_CICLOS+3.
// No backpressure: pattern manager must answer trocar_comando within 1 cycle. Optional COMBO_EN adds combo scoring.
module avaliador_de_comandos
  import pacote_ritmo::*;
#(
  parameter int JANELA_CICLOS = 50_000_000,
  parameter int LARG_PONTOS   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   iniciar,
  input  logic [LARG_CMD-1:0]    botoes,
  input  logic [LARG_CMD-1:0]    prox_comando,
  input  logic                   fim_de_jogo,
  output logic                   trocar_comando,
  output logic [LARG_CMD-1:0]    comando_atual,
  output logic                   jogando,
  output logic                   acerto,
  output logic                   erro,
  output logic [LARG_PONTOS-1:0] pontos,
  output logic [LARG_PONTOS-1:0] erros
`ifdef COMBO_EN
  ,output logic [3:0]            combo
`endif
);

  localparam int LARG_CONT = $clog2(JANELA_CICLOS);
  localparam logic [LARG_CONT-1:0]   ULTIMO = LARG_CONT'(JANELA_CICLOS - 1);
  localparam logic [LARG_PONTOS-1:0] MAX_P  = '1;

  estado_t               estado;
  logic [LARG_CONT-1:0]  contador;
  logic [LARG_CMD-1:0]   borda;
  logic [LARG_CMD-1:0]   pressao;
  logic                  pressionado;
  logic [LARG_CMD-1:0]   press_final;
  logic [1:0]            veredito;
  logic [LARG_PONTOS:0]  incremento;
  logic [LARG_PONTOS:0]  soma_pontos;
  logic [LARG_PONTOS-1:0] pontos_sat;
  logic [LARG_PONTOS-1:0] erros_sat;

  detector_de_borda #(.LARGURA(LARG_CMD)) u_borda (
    .clk     (clk),
    .reset   (reset),
    .entrada (botoes),
    .borda   (borda)
  );

  // An edge on the window's last cycle must still be judged in the same transition.
  always_comb begin
    press_final = pressionado ? pressao : borda;
    veredito    = julgar(comando_atual, press_final);
    incremento  = {{LARG_PONTOS{1'b0}}, 1'b1};
`ifdef COMBO_EN
    if (combo >= 4'd4) incremento = {{(LARG_PONTOS-1){1'b0}}, 2'b10};
`endif
    soma_pontos = {1'b0, pontos} + incremento;
    pontos_sat  = (soma_pontos > {1'b0, MAX_P}) ? MAX_P : soma_pontos[LARG_PONTOS-1:0];
    erros_sat   = (erros == MAX_P) ? erros : erros + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado         <= OCIOSO;
      trocar_comando <= 1'b0;
      comando_atual  <= '0;
      jogando        <= 1'b0;
      acerto         <= 1'b0;
      erro           <= 1'b0;
      pontos         <= '0;
      erros          <= '0;
      contador       <= '0;
      pressao        <= '0;
      pressionado    <= 1'b0;
`ifdef COMBO_EN
      combo          <= 4'd0;
`endif
    end else begin
      trocar_comando <= 1'b0;
      acerto         <= 1'b0;
      erro           <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (iniciar) begin
            pontos         <= '0;
            erros          <= '0;
`ifdef COMBO_EN
            combo          <= 4'd0;
`endif
            trocar_comando <= 1'b1;
            jogando        <= 1'b1;
            estado         <= PEDE;
          end
        end
        PEDE: estado <= CARREGA;
        CARREGA: begin
          if (fim_de_jogo) begin
            jogando <= 1'b0;
            estado  <= FIM;
          end else begin
            comando_atual <= prox_comando;
            contador      <= '0;
            pressao       <= '0;
            pressionado   <= 1'b0;
            estado        <= ESPERA;
          end
        end
        ESPERA: begin
          contador <= contador + 1'b1;
          if (!pressionado && (borda != '0)) begin
            pressao     <= borda;
            pressionado <= 1'b1;
          end
          if (contador == ULTIMO) begin
            acerto <= veredito[1];
            erro   <= veredito[0];
            if (veredito[1]) begin
              pontos <= pontos_sat;
`ifdef COMBO_EN
              combo  <= (combo == 4'hF) ? combo : combo + 4'd1;
`endif
            end
            if (veredito[0]) begin
              erros <= erros_sat;
`ifdef COMBO_EN
              combo <= 4'd0;
`endif
            end
            estado <= AVALIA;
          end
        end
        AVALIA: begin
          trocar_comando <= 1'b1;
          estado         <= PEDE;
        end
        FIM: if (!iniciar) estado <= OCIOSO;
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_avaliador_de_comandos.sv
// Directed bench for avaliador_de_comandos with an 8-cycle window; inputs change and outputs are read on negedges.
module tb_avaliador_de_comandos;

  localparam int J = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic [3:0] botoes = 4'd0;
  logic [3:0] prox_comando = 4'd0;
  logic       fim_de_jogo = 1'b0;
  logic       trocar_comando;
  logic [3:0] comando_atual;
  logic       jogando, acerto, erro;
  logic [7:0] pontos, erros;
`ifdef COMBO_EN
  logic [3:0] combo;
`endif

  int testes = 0;
  int falhas = 0;
  int ciclo = 0;
  int t_trocar = 0;

  always #5 clk = ~clk;
  always @(posedge clk) ciclo <= ciclo + 1;

  avaliador_de_comandos #(.JANELA_CICLOS(J), .LARG_PONTOS(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .iniciar        (iniciar),
    .botoes         (botoes),
    .prox_comando   (prox_comando),
    .fim_de_jogo    (fim_de_jogo),
    .trocar_comando (trocar_comando),
    .comando_atual  (comando_atual),
    .jogando        (jogando),
    .acerto         (acerto),
    .erro           (erro),
    .pontos         (pontos),
    .erros          (erros)
`ifdef COMBO_EN
    ,.combo         (combo)
`endif
  );

  // Waits for trocar_comando, serves cmd, plays up to two presses at window cycles c1/c2,
  // and returns at the AVALIA negedge (or the FIM negedge when fim=1).
  task automatic janela(input logic [3:0] cmd, input logic fim,
                        input int c1, input logic [3:0] v1,
                        input int c2, input logic [3:0] v2,
                        output logic a, output logic e, output logic [3:0] cmd_obs,
                        output logic tr_carrega, output int periodo);
    int n = 0;
    a = 1'bx; e = 1'bx; cmd_obs = 4'hx; tr_carrega = 1'bx; periodo = -1;
    while (trocar_comando !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (trocar_comando !== 1'b1) begin
      testes++;
      falhas++;
      $display("FAIL timeout_trocar: trocar_comando=%b, required 1 within 30 cycles", trocar_comando);
      return;
    end
    periodo  = ciclo - t_trocar;
    t_trocar = ciclo;
    iniciar = 1'b0;
    prox_comando = cmd;
    fim_de_jogo = fim;
    @(negedge clk);
    tr_carrega = trocar_comando;
    @(negedge clk);
    fim_de_jogo = 1'b0;
    cmd_obs = comando_atual;
    if (fim) return;
    for (int w = 0; w < J; w++) begin
      if (w == c1 + 1 || w == c2 + 1) botoes = 4'd0;
      if (w == c1) botoes = v1;
      if (w == c2) botoes = v2;
      @(negedge clk);
    end
    a = acerto;
    e = erro;
    if (c1 >= 0) botoes = 4'd0;
  endtask

  logic       a, e, tr;
  logic [3:0] c;
  int         p;

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    testes++;
    if ({trocar_comando, jogando, acerto, erro, comando_atual, pontos, erros} !== 24'd0) begin
      falhas++;
      $display("FAIL reset_outputs: got %h, required 0",
               {trocar_comando, jogando, acerto, erro, comando_atual, pontos, erros});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_inicio();
    iniciar = 1'b1;
    janela(4'd2, 1'b0, 3, 4'b0100, -10, 4'd0, a, e, c, tr, p);
    testes++; if (c !== 4'd2) begin falhas++; $display("FAIL latch_cmd: got %h, required 2", c); end
    testes++; if (tr !== 1'b0) begin falhas++; $display("FAIL trocar_width: got %b, required 0", tr); end
    testes++; if ({a, e} !== 2'b10) begin falhas++; $display("FAIL hit_cmd2: got %b, required 10", {a, e}); end
    testes++; if (pontos !== 8'd1) begin falhas++; $display("FAIL pontos_1: got %0d, required 1", pontos); end
    testes++; if (jogando !== 1'b1) begin falhas++; $display("FAIL jogando: got %b, required 1", jogando); end
  endtask

  task automatic test_erros();
    janela(4'd1, 1'b0, -10, 4'd0, -10, 4'd0, a, e, c, tr, p);
    testes++; if (p !== J + 3) begin falhas++; $display("FAIL period: got %0d, required %0d", p, J + 3); end
    testes++; if ({a, e} !== 2'b01) begin falhas++; $display("FAIL miss: got %b, required 01", {a, e}); end
    testes++; if (erros !== 8'd1) begin falhas++; $display("FAIL erros_1: got %0d, required 1", erros); end
    janela(4'd0, 1'b0, 2, 4'b0011, -10, 4'd0, a, e, c, tr, p);
    testes++; if ({a, e, erros} !== {2'b01, 8'd2}) begin falhas++; $display("FAIL two_bits: got %b/%0d, required 01/2", {a, e}, erros); end
    janela(4'd3, 1'b0, 1, 4'b0001, 4, 4'b1000, a, e, c, tr, p);
    testes++; if ({a, e, erros} !== {2'b01, 8'd3}) begin falhas++; $display("FAIL first_wrong: got %b/%0d, required 01/3", {a, e}, erros); end
    janela(4'd3, 1'b0, 1, 4'b1000, 4, 4'b0001, a, e, c, tr, p);
    testes++; if ({a, e, pontos} !== {2'b10, 8'd2}) begin falhas++; $display("FAIL first_right: got %b/%0d, required 10/2", {a, e}, pontos); end
    janela(4'd1, 1'b0, 7, 4'b0010, -10, 4'd0, a, e, c, tr, p);
    testes++; if ({a, e, pontos} !== {2'b10, 8'd3}) begin falhas++; $display("FAIL last_cycle: got %b/%0d, required 10/3", {a, e}, pontos); end
    botoes = 4'b0001;
    janela(4'd0, 1'b0, -10, 4'd0, -10, 4'd0, a, e, c, tr, p);
    botoes = 4'd0;
    testes++; if ({a, e, erros} !== {2'b01, 8'd4}) begin falhas++; $display("FAIL held_button: got %b/%0d, required 01/4", {a, e}, erros); end
  endtask

  task automatic test_pausa();
    janela(4'hF, 1'b0, -10, 4'd0, -10, 4'd0, a, e, c, tr, p);
    testes++; if ({a, e, pontos, erros} !== {2'b00, 8'd3, 8'd4}) begin falhas++; $display("FAIL pause_idle: got %b/%0d/%0d, required 00/3/4", {a, e}, pontos, erros); end
    janela(4'h7, 1'b0, -10, 4'd0, -10, 4'd0, a, e, c, tr, p);
    testes++; if ({a, e} !== 2'b00) begin falhas++; $display("FAIL cmd7_idle: got %b, required 00", {a, e}); end
    janela(4'hF, 1'b0, 0, 4'b0001, -10, 4'd0, a, e, c, tr, p);
    testes++; if ({a, e, erros} !== {2'b01, 8'd5}) begin falhas++; $display("FAIL pause_press: got %b/%0d, required 01/5", {a, e}, erros); end
  endtask

  task automatic test_saturacao();
    for (int i = 0; i < 251; i++) janela(4'd1, 1'b0, 2, 4'b0010, -10, 4'd0, a, e, c, tr, p);
    testes++; if (pontos !== 8'd254) begin falhas++; $display("FAIL pontos_254: got %0d, required 254", pontos); end
    for (int i = 0; i < 49; i++) janela(4'd1, 1'b0, 2, 4'b0010, -10, 4'd0, a, e, c, tr, p);
    testes++; if ({pontos, erros} !== {8'd255, 8'd5}) begin falhas++; $display("FAIL saturate: got %0d/%0d, required 255/5", pontos, erros); end
  endtask

  task automatic test_reset_meio();
    int n = 0;
    logic ativo = 1'b0;
    while (trocar_comando !== 1'b1 && n < 30) begin @(negedge clk); n++; end
    prox_comando = 4'd2;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    testes++;
    if ({trocar_comando, jogando, acerto, erro, comando_atual, pontos, erros} !== 24'd0) begin
      falhas++;
      $display("FAIL mid_reset: got %h, required 0",
               {trocar_comando, jogando, acerto, erro, comando_atual, pontos, erros});
    end
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      ativo = ativo | trocar_comando | jogando;
    end
    testes++; if (ativo !== 1'b0) begin falhas++; $display("FAIL idle_after_reset: got %b, required 0", ativo); end
  endtask

  task automatic test_fim();
    iniciar = 1'b1;
    janela(4'd0, 1'b0, 1, 4'b0001, -10, 4'd0, a, e, c, tr, p);
    janela(4'd1, 1'b0, -10, 4'd0, -10, 4'd0, a, e, c, tr, p);
    janela(4'd2, 1'b1, -10, 4'd0, -10, 4'd0, a, e, c, tr, p);
    testes++;
    if ({jogando, pontos, erros} !== {1'b0, 8'd1, 8'd1}) begin
      falhas++;
      $display("FAIL fim_hold: got %b/%0d/%0d, required 0/1/1", jogando, pontos, erros);
    end
    repeat (3) @(negedge clk);
    testes++; if ({trocar_comando, jogando} !== 2'b00) begin falhas++; $display("FAIL fim_idle: got %b, required 00", {trocar_comando, jogando}); end
    iniciar = 1'b1;
    janela(4'hF, 1'b0, -10, 4'd0, -10, 4'd0, a, e, c, tr, p);
    testes++; if ({pontos, erros} !== 16'd0) begin falhas++; $display("FAIL restart_clear: got %0d/%0d, required 0/0", pontos, erros); end
  endtask

`ifdef COMBO_EN
  task automatic test_combo();
    for (int i = 0; i < 5; i++) janela(4'd2, 1'b0, 1, 4'b0100, -10, 4'd0, a, e, c, tr, p);
    testes++; if ({pontos, combo} !== {8'd6, 4'd5}) begin falhas++; $display("FAIL combo_hits: got %0d/%0d, required 6/5", pontos, combo); end
    janela(4'd2, 1'b0, -10, 4'd0, -10, 4'd0, a, e, c, tr, p);
    testes++; if (combo !== 4'd0) begin falhas++; $display("FAIL combo_clear: got %0d, required 0", combo); end
  endtask
`endif

  initial begin
    test_reset();
    test_inicio();
    test_erros();
    test_pausa();
    test_saturacao();
    test_reset_meio();
    test_fim();
`ifdef COMBO_EN
    test_combo();
`endif
    $display("[TB] %0d tests run, %0d failed", testes, falhas);
    $finish;
  end

endmodule
